// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// opcode constants and the ALUop / PCSrc select encodings.
package mc_ctrl_pkg;

  // Legacy states keep their low three bits; HALT and TRAP extend into bit 3.
  typedef enum logic [3:0] {
    S_IF   = 4'b0000,
    S_ID   = 4'b0001,
    S_MA   = 4'b0010,
    S_MEM  = 4'b0011,
    S_MWB  = 4'b0100,
    S_BR   = 4'b0101,
    S_EXE  = 4'b0110,
    S_WB   = 4'b0111,
    S_HALT = 4'b1000,
    S_TRAP = 4'b1001
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SLT  = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;

  localparam logic [2:0] PC_NEXT   = 3'b000;
  localparam logic [2:0] PC_BRANCH = 3'b001;
  localparam logic [2:0] PC_JR     = 3'b010;
  localparam logic [2:0] PC_JUMP   = 3'b011;
  localparam logic [2:0] PC_TRAP   = 3'b100;

endpackage

// File: rtl/mc_op_decode.sv
// One-hot opcode classifier; anything not recognised is flagged illegal.
module mc_op_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output logic            is_alu,
  output logic            is_mem,
  output logic            is_br,
  output logic            is_jmp,
  output logic            is_halt,
  output logic            illegal
);

  function automatic logic isOp(input logic [OP_W-1:0] opcode, input logic [5:0] code);
    return opcode == OP_W'(code);
  endfunction

  assign is_alu  = isOp(op, OP_ADD) | isOp(op, OP_SUB) | isOp(op, OP_ADDI) |
                   isOp(op, OP_OR)  | isOp(op, OP_AND) | isOp(op, OP_ORI)  |
                   isOp(op, OP_MOVE) | isOp(op, OP_SLT) | isOp(op, OP_SLL);
  assign is_mem  = isOp(op, OP_LW) | isOp(op, OP_SW);
  assign is_br   = isOp(op, OP_BEQ) | isOp(op, OP_BNE);
  assign is_jmp  = isOp(op, OP_J) | isOp(op, OP_JR) | isOp(op, OP_JAL);
  assign is_halt = isOp(op, OP_HALT);
  assign illegal = !(is_alu | is_mem | is_br | is_jmp | is_halt);

endmodule

// File: rtl/mc_control_v2.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB with memory
// wait states, sticky HALT and an illegal-opcode trap, and decodes strobes.
module mc_control_v2
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic [2:0]      ALUop,
  output logic [2:0]      PCSrc,
  output logic [1:0]      RegOut,
  output logic [1:0]      ExtSel,
  output logic            PCWre,
  output logic            IRWre,
  output logic            RegWre,
  output logic            ALUSrcB,
  output logic            ALUM2Reg,
  output logic            DataMemRW,
  output logic            InsMemRW,
  output logic            WrRegData,
  output logic [3:0]      state,
  output logic            halted,
  output logic            trap
);

  state_e state_q, state_d;
  logic   isAlu, isMem, isBr, isJmp, isHalt, isIllegal;

  function automatic logic isOp(input logic [OP_W-1:0] opcode, input logic [5:0] code);
    return opcode == OP_W'(code);
  endfunction

  mc_op_decode #(.OP_W(OP_W)) u_decode (
    .op      (op),
    .is_alu  (isAlu),
    .is_mem  (isMem),
    .is_br   (isBr),
    .is_jmp  (isJmp),
    .is_halt (isHalt),
    .illegal (isIllegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:   if (imem_ready) state_d = S_ID;
      S_ID: begin
        if (isAlu)       state_d = S_EXE;
        else if (isBr)   state_d = S_BR;
        else if (isMem)  state_d = S_MA;
        else if (isJmp)  state_d = S_IF;
        else if (isHalt) state_d = S_HALT;
        else             state_d = TRAP_EN ? S_TRAP : S_IF;
      end
      S_EXE:  state_d = S_WB;
      S_MA:   state_d = S_MEM;
      S_MEM:  if (dmem_ready) state_d = isOp(op, OP_LW) ? S_MWB : S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    ALUop     = ALU_ADD;
    PCSrc     = PC_NEXT;
    RegOut    = 2'b00;
    ExtSel    = 2'b00;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUM2Reg  = 1'b0;
    DataMemRW = 1'b0;
    InsMemRW  = 1'b0;
    WrRegData = !isOp(op, OP_JAL);
    halted    = 1'b0;
    trap      = 1'b0;

    // The IR is not yet valid in IF, so datapath selects stay at zero there.
    if (state_q != S_IF) begin
      if (isOp(op, OP_SUB) || isOp(op, OP_BEQ) || isOp(op, OP_BNE)) ALUop = ALU_SUB;
      else if (isOp(op, OP_SLT))                          ALUop = ALU_SLT;
      else if (isOp(op, OP_SLL))                          ALUop = ALU_SLL;
      else if (isOp(op, OP_OR) || isOp(op, OP_ORI))       ALUop = ALU_OR;
      else if (isOp(op, OP_AND))                          ALUop = ALU_AND;
      ALUSrcB  = isOp(op, OP_ADDI) | isOp(op, OP_ORI) | isOp(op, OP_SW) |
                 isOp(op, OP_LW)   | isOp(op, OP_SLL);
      ALUM2Reg = isOp(op, OP_LW);
      if (isOp(op, OP_ADD) || isOp(op, OP_SUB) || isOp(op, OP_OR) || isOp(op, OP_AND) ||
          isOp(op, OP_MOVE) || isOp(op, OP_SLT) || isOp(op, OP_SLL))
        RegOut = 2'b10;
      else if (isOp(op, OP_ADDI) || isOp(op, OP_ORI) || isOp(op, OP_LW))
        RegOut = 2'b01;
      if (isOp(op, OP_ADDI) || isOp(op, OP_LW) || isOp(op, OP_SW) ||
          isOp(op, OP_BEQ) || isOp(op, OP_BNE))
        ExtSel = 2'b10;
      else if (isOp(op, OP_ORI))
        ExtSel = 2'b01;
    end

    case (state_q)
      S_IF:   IRWre = imem_ready & rst_n;
      S_ID: begin
        if (isJmp) begin
          PCWre  = 1'b1;
          PCSrc  = isOp(op, OP_JR) ? PC_JR : PC_JUMP;
          RegWre = isOp(op, OP_JAL);
        end else if (isIllegal && !TRAP_EN) begin
          PCWre = 1'b1;
        end
      end
      S_MEM: begin
        DataMemRW = isOp(op, OP_SW);
        PCWre     = isOp(op, OP_SW) & dmem_ready;
      end
      S_MWB, S_WB: begin
        RegWre = 1'b1;
        PCWre  = 1'b1;
      end
      S_BR: begin
        PCWre = 1'b1;
        if ((isOp(op, OP_BEQ) && zero) || (isOp(op, OP_BNE) && !zero)) PCSrc = PC_BRANCH;
      end
      S_TRAP: begin
        PCWre = 1'b1;
        PCSrc = PC_TRAP;
        trap  = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_v2.sv
// Directed-vector bench for mc_control_v2: walks each instruction class
// through its states and compares strobes against hand-computed values.
module tb_mc_control_v2;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       imem_ready;
  logic       dmem_ready;
  logic [2:0] ALUop;
  logic [2:0] PCSrc;
  logic [1:0] RegOut;
  logic [1:0] ExtSel;
  logic       PCWre, IRWre, RegWre, ALUSrcB, ALUM2Reg, DataMemRW, InsMemRW, WrRegData;
  logic [3:0] state;
  logic       halted;
  logic       trap;

  int vectorCount = 0;
  int missCount   = 0;

  mc_control_v2 #(.OP_W(6), .TRAP_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .ALUop      (ALUop),
    .PCSrc      (PCSrc),
    .RegOut     (RegOut),
    .ExtSel     (ExtSel),
    .PCWre      (PCWre),
    .IRWre      (IRWre),
    .RegWre     (RegWre),
    .ALUSrcB    (ALUSrcB),
    .ALUM2Reg   (ALUM2Reg),
    .DataMemRW  (DataMemRW),
    .InsMemRW   (InsMemRW),
    .WrRegData  (WrRegData),
    .state      (state),
    .halted     (halted),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic runAlu(input logic [5:0] code, input logic [2:0] expAlu, input logic expSrcB,
                        input logic [1:0] expRegOut, input logic [1:0] expExt);
    op = code;
    checkOutput("alu.if.state", state, 4'h0);
    applyStimulus();
    checkOutput("alu.id.state", state, 4'h1);
    checkOutput("alu.id.aluop", ALUop, expAlu);
    checkOutput("alu.id.srcb", ALUSrcB, expSrcB);
    checkOutput("alu.id.regout", RegOut, expRegOut);
    checkOutput("alu.id.extsel", ExtSel, expExt);
    checkOutput("alu.id.pcwre", PCWre, 1'b0);
    applyStimulus();
    checkOutput("alu.exe.state", state, 4'h6);
    checkOutput("alu.exe.regwre", RegWre, 1'b0);
    checkOutput("alu.exe.pcwre", PCWre, 1'b0);
    applyStimulus();
    checkOutput("alu.wb.state", state, 4'h7);
    checkOutput("alu.wb.regwre", RegWre, 1'b1);
    checkOutput("alu.wb.pcwre", PCWre, 1'b1);
    checkOutput("alu.wb.pcsrc", PCSrc, 3'b000);
    applyStimulus();
    checkOutput("alu.end.state", state, 4'h0);
  endtask

  task automatic runBranch(input logic [5:0] code, input logic zeroVal, input logic [2:0] expSrc);
    op = code;
    applyStimulus();
    checkOutput("br.id.state", state, 4'h1);
    checkOutput("br.id.aluop", ALUop, 3'b001);
    checkOutput("br.id.extsel", ExtSel, 2'b10);
    zero = ~zeroVal;
    applyStimulus();
    zero = zeroVal;
    #1;
    checkOutput("br.br.state", state, 4'h5);
    checkOutput("br.br.pcwre", PCWre, 1'b1);
    checkOutput("br.br.pcsrc", PCSrc, expSrc);
    applyStimulus();
    checkOutput("br.end.state", state, 4'h0);
  endtask

  task automatic runJump(input logic [5:0] code, input logic [2:0] expSrc, input logic expRegWre);
    op = code;
    applyStimulus();
    checkOutput("jmp.id.state", state, 4'h1);
    checkOutput("jmp.id.pcwre", PCWre, 1'b1);
    checkOutput("jmp.id.pcsrc", PCSrc, expSrc);
    checkOutput("jmp.id.regwre", RegWre, expRegWre);
    checkOutput("jmp.id.wrregdata", WrRegData, !expRegWre);
    applyStimulus();
    checkOutput("jmp.end.state", state, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0; op = 6'b010000; zero = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    #1;
    checkOutput("rst.state", state, 4'h0);
    checkOutput("rst.irwre", IRWre, 1'b0);
    checkOutput("rst.pcwre", PCWre, 1'b0);
    checkOutput("rst.aluop", ALUop, 3'b000);
    checkOutput("rst.wrregdata", WrRegData, 1'b1);
    checkOutput("rst.insmemrw", InsMemRW, 1'b0);
    op = 6'b111010;
    #1;
    checkOutput("rst.wrregdata.jal", WrRegData, 1'b0);
    applyStimulus();
    applyStimulus();
    checkOutput("rst.hold.state", state, 4'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("if.irwre", IRWre, 1'b1);

    imem_ready = 1'b0;
    #1;
    checkOutput("if.wait.irwre", IRWre, 1'b0);
    applyStimulus();
    checkOutput("if.wait.state", state, 4'h0);
    imem_ready = 1'b1;

    runAlu(6'b000000, 3'b000, 1'b0, 2'b10, 2'b00);
    runAlu(6'b000001, 3'b001, 1'b0, 2'b10, 2'b00);
    runAlu(6'b000010, 3'b000, 1'b1, 2'b01, 2'b10);
    runAlu(6'b010010, 3'b101, 1'b1, 2'b01, 2'b01);
    runAlu(6'b100111, 3'b010, 1'b0, 2'b10, 2'b00);
    runAlu(6'b011000, 3'b100, 1'b1, 2'b10, 2'b00);
    runAlu(6'b010001, 3'b110, 1'b0, 2'b10, 2'b00);

    // lw with two data-memory wait cycles: MEM is held for three cycles.
    op = 6'b110001; dmem_ready = 1'b0;
    applyStimulus();
    checkOutput("lw.id.regout", RegOut, 2'b01);
    checkOutput("lw.id.srcb", ALUSrcB, 1'b1);
    applyStimulus();
    checkOutput("lw.ma.state", state, 4'h2);
    applyStimulus();
    checkOutput("lw.mem1.state", state, 4'h3);
    checkOutput("lw.mem1.dmemrw", DataMemRW, 1'b0);
    checkOutput("lw.mem1.pcwre", PCWre, 1'b0);
    applyStimulus();
    checkOutput("lw.mem2.state", state, 4'h3);
    applyStimulus();
    checkOutput("lw.mem3.state", state, 4'h3);
    dmem_ready = 1'b1;
    applyStimulus();
    checkOutput("lw.mwb.state", state, 4'h4);
    checkOutput("lw.mwb.regwre", RegWre, 1'b1);
    checkOutput("lw.mwb.m2reg", ALUM2Reg, 1'b1);
    checkOutput("lw.mwb.pcwre", PCWre, 1'b1);
    applyStimulus();
    checkOutput("lw.end.state", state, 4'h0);

    runBranch(6'b110101, 1'b0, 3'b001);
    runBranch(6'b110101, 1'b1, 3'b000);
    runBranch(6'b110100, 1'b1, 3'b001);
    runBranch(6'b110100, 1'b0, 3'b000);

    runJump(6'b111010, 3'b011, 1'b1);
    runJump(6'b111001, 3'b010, 1'b0);
    runJump(6'b111000, 3'b011, 1'b0);

    op = 6'b110000;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("sw.mem.state", state, 4'h3);
    checkOutput("sw.mem.dmemrw", DataMemRW, 1'b1);
    checkOutput("sw.mem.pcwre", PCWre, 1'b1);
    checkOutput("sw.mem.regwre", RegWre, 1'b0);
    applyStimulus();
    checkOutput("sw.end.state", state, 4'h0);

    op = 6'b111110;
    applyStimulus();
    checkOutput("trap.id.pcwre", PCWre, 1'b0);
    applyStimulus();
    checkOutput("trap.state", state, 4'h9);
    checkOutput("trap.pulse", trap, 1'b1);
    checkOutput("trap.pcsrc", PCSrc, 3'b100);
    checkOutput("trap.pcwre", PCWre, 1'b1);
    applyStimulus();
    checkOutput("trap.end.state", state, 4'h0);
    checkOutput("trap.end.pulse", trap, 1'b0);

    // Asynchronous reset in the middle of a stalled sw store.
    op = 6'b110000; dmem_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("swrst.mem.dmemrw", DataMemRW, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("swrst.state", state, 4'h0);
    checkOutput("swrst.dmemrw", DataMemRW, 1'b0);
    checkOutput("swrst.pcwre", PCWre, 1'b0);
    applyStimulus();
    rst_n = 1'b1; dmem_ready = 1'b1;
    runAlu(6'b100000, 3'b000, 1'b0, 2'b10, 2'b00);

    op = 6'b111111;
    applyStimulus();
    applyStimulus();
    checkOutput("halt.state", state, 4'h8);
    for (int i = 0; i < 20; i++) begin
      imem_ready = i[0];
      applyStimulus();
      checkOutput("halt.halted", halted, 1'b1);
      checkOutput("halt.pcwre", PCWre, 1'b0);
    end
    checkOutput("halt.hold.state", state, 4'h8);
    rst_n = 1'b0;
    #1;
    checkOutput("halt.rst.halted", halted, 1'b0);
    checkOutput("halt.rst.state", state, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/mc_control_v2.md
# mc_control_v2

Multi-cycle CPU control unit, successor of the current fixed-width control FSM. It decodes the opcode and walks each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath strobe and mux select. New over the previous generation: a parametrised opcode width, `bne`, wait-state handshakes on instruction and data memory, a sticky `HALT` state, and an illegal-opcode trap. It sits between the instruction register and the datapath (PC, register file, ALU, data memory).

## Interface
- `OP_W`, 6: opcode width. Opcode constants are zero-extended to `OP_W`.
- `TRAP_EN`, 1: 1 = an illegal opcode enters `TRAP`; 0 = an illegal opcode is a 2-cycle NOP.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `op`  in  `OP_W`  opcode from IR. Stable from `ID` until the instruction ends.
- `zero`  in  1  ALU zero flag, valid in `BR`.
- `imem_ready`  in  1  instruction word valid.
- `dmem_ready`  in  1  data memory access complete.
- `ALUop`  out  3  ALU function.
- `PCSrc`  out  3  next-PC select.
- `RegOut`  out  2  destination-register select.
- `ExtSel`  out  2  immediate-extend mode.
- `PCWre`, `IRWre`, `RegWre`, `ALUSrcB`, `ALUM2Reg`, `DataMemRW`, `InsMemRW`, `WrRegData`  out  1 each  datapath strobes and selects.
- `state`  out  4  current state.
- `halted`  out  1  high in `HALT`.
- `trap`  out  1  one-cycle pulse in `TRAP`.

## Operation
- State encodings:
  - `IF`=0000, `ID`=0001, `MA`=0010, `MEM`=0011, `MWB`=0100, `BR`=0101, `EXE`=0110, `WB`=0111, `HALT`=1000, `TRAP`=1001.
  - The low 3 bits of the legacy states are unchanged.
- Transitions:
  - `IF` → `ID` when `imem_ready`; otherwise stay in `IF`.
  - `ID`, ALU ops (add, sub, addi, or, and, ori, move, slt, sll) → `EXE` → `WB` → `IF`.
  - `ID`, beq/bne → `BR` → `IF`.
  - `ID`, lw/sw → `MA` → `MEM`.
  - `MEM`: stay while `!dmem_ready`. When ready, lw → `MWB` → `IF` and sw → `IF`.
  - `ID`, j/jr/jal → `IF`.
  - `ID`, halt → `HALT`. `HALT` is left only by reset.
  - `ID`, illegal opcode → `TRAP` → `IF` (when `TRAP_EN`=0: `ID` → `IF`, PC+4).
- The PC is written once per instruction, in that instruction's final cycle:
  - `PCWre`=1 in `WB`, `BR`, `MWB`, `TRAP`, in `MEM`&sw&`dmem_ready`, and in `ID`&(j|jr|jal|illegal&!`TRAP_EN`).
  - `PCWre`=0 in every other cycle.
- `PCSrc` values:
  - 000 = PC+4.
  - 001 = branch target, selected when (beq&`zero`)|(bne&!`zero`), evaluated in `BR`.
  - 010 = jr.
  - 011 = j/jal.
  - 100 = trap vector.
- `IRWre`=`IF`&`imem_ready`.
- `RegWre` is asserted in `WB`, in `MWB`, and in `ID`&jal.
- `DataMemRW`=`MEM`&sw.
- `InsMemRW`=0.
- `WrRegData`=!jal.
- `ALUop`:
  - add/addi/lw/sw/move = 000
  - sub/beq/bne = 001
  - slt = 010
  - sll = 100
  - or/ori = 101
  - and = 110
- `ALUSrcB`: addi, ori, sw, lw, sll.
- `ALUM2Reg`: lw.
- `RegOut`:
  - 10 for R-type (add, sub, or, and, move, slt, sll).
  - 01 for addi, ori, lw.
  - 00 otherwise.
- `ExtSel`:
  - 10 for addi, lw, sw, beq, bne.
  - 01 for ori.
  - 00 otherwise.
- Outputs are a Moore/Mealy decode of `state` plus `op`. All strobes are 0 outside the states named above.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `state`=`IF` immediately.
  - `PCWre`, `IRWre`, `RegWre`, `DataMemRW`, `trap` and `halted` = 0.
  - Selects = 0, except `WrRegData`, which is 1 unless `op`=jal.
- Reset mid-instruction abandons the instruction. No partial write may occur after the asynchronous assertion.
- Cycle counts with zero wait:
  - ALU: 4
  - branch: 3
  - jump: 2
  - sw: 4
  - lw: 5
  - trap: 3
- Each `imem_ready`/`dmem_ready` low cycle adds exactly one cycle.
- `dmem_ready` is sampled only in `MEM`. `imem_ready` is sampled only in `IF`.
- A `zero` change outside `BR` has no effect.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum (4-bit),
  - the opcode constants (add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, move 100000, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt 111111),
  - the ALUop and PCSrc encodings.
- One sub-module, `mc_op_decode`: the combinational one-hot opcode classifier (`is_alu`, `is_mem`, `is_br`, `is_jmp`, `is_halt`, `illegal`). The FSM and output decode stay in the top module.

## Test plan
- add (000000), `imem_ready`=1: states 0→1→6→7→0. `RegWre`=1 only in `WB`; `PCWre`=1 with `PCSrc`=000 in `WB`.
- lw with `dmem_ready` low 2 cycles: `MEM` held 3 cycles, then `MWB` with `RegWre`=1 and `ALUM2Reg`=1. 7 cycles total.
- bne with `zero`=0, then with `zero`=1: `PCSrc`=001, then 000 in `BR`.
- jal: in `ID`, `RegWre`=1, `WrRegData`=0, `PCSrc`=011, `PCWre`=1; next state is `IF`.
- opcode 111110, `TRAP_EN`=1: `TRAP` with `trap`=1 for one cycle and `PCSrc`=100, then `IF`. With halt (111111): `halted` stays 1 and `PCWre` stays 0 for 20 cycles.
- `rst_n` pulsed low during `MEM` of sw: `DataMemRW` drops the same cycle, `state`=0000, and after release the next fetch proceeds normally.
